// File: rtl/nvdla_sdp_dp2wdma_pack.sv
// Packs IN_WIDTH datapath beats into OUT_WIDTH WDMA words with a slot mask.
// Optional stall counter enabled by NVDLA_SDP_PACK_PERF_EN.
module nvdla_sdp_dp2wdma_pack #(
  parameter  int IN_WIDTH  = 128,
  parameter  int OUT_WIDTH = 256,
  localparam int RATIO     = OUT_WIDTH / IN_WIDTH,
  localparam int CW        = $clog2(RATIO)
) (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rstn,
  input  logic                 op_load,
  input  logic                 dp_pvld,
  output logic                 dp_prdy,
  input  logic [IN_WIDTH-1:0]  dp_pd,
  input  logic                 dp_last,
  output logic                 sdp_dp2wdma_valid,
  input  logic                 sdp_dp2wdma_ready,
  output logic [OUT_WIDTH-1:0] sdp_dp2wdma_pd,
  output logic [RATIO-1:0]     sdp_dp2wdma_mask,
  output logic [31:0]          dp2reg_pack_stall
);

  logic [CW-1:0]        cnt;
  logic [OUT_WIDTH-1:0] asm_q;
  logic [OUT_WIDTH-1:0] word_nxt;
  logic [RATIO-1:0]     mask_nxt;
  logic                 cmpl;
  logic                 out_free;
  logic                 acc;

  assign cmpl     = (cnt == CW'(RATIO - 1)) | dp_last;
  assign out_free = ~sdp_dp2wdma_valid | sdp_dp2wdma_ready;
  assign dp_prdy  = ~cmpl | out_free;
  assign acc      = dp_pvld & dp_prdy;

  // slots above cnt in asm_q are always zero, so the new word needs no masking
  always_comb begin
    word_nxt = asm_q;
    word_nxt[cnt*IN_WIDTH +: IN_WIDTH] = dp_pd;
    mask_nxt = '0;
    for (int i = 0; i < RATIO; i++) begin
      mask_nxt[i] = (CW'(i) <= cnt);
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      cnt   <= '0;
      asm_q <= '0;
    end else if (op_load) begin
      cnt   <= '0;
      asm_q <= '0;
    end else if (acc) begin
      if (cmpl) begin
        cnt   <= '0;
        asm_q <= '0;
      end else begin
        cnt   <= cnt + CW'(1);
        asm_q <= word_nxt;
      end
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      sdp_dp2wdma_valid <= 1'b0;
      sdp_dp2wdma_pd    <= '0;
      sdp_dp2wdma_mask  <= '0;
    end else if (acc & cmpl & ~op_load) begin
      sdp_dp2wdma_valid <= 1'b1;
      sdp_dp2wdma_pd    <= word_nxt;
      sdp_dp2wdma_mask  <= mask_nxt;
    end else if (sdp_dp2wdma_ready) begin
      sdp_dp2wdma_valid <= 1'b0;
    end
  end

`ifdef NVDLA_SDP_PACK_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      stall_q <= '0;
    end else if (op_load) begin
      stall_q <= '0;
    end else if (sdp_dp2wdma_valid & ~sdp_dp2wdma_ready
                 & (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign dp2reg_pack_stall = stall_q;
`else
  assign dp2reg_pack_stall = 32'd0;
`endif

endmodule

// File: doc/nvdla_sdp_dp2wdma_pack.md
NVDLA_SDP_DP2WDMA_PACK -- requirements
Module: nvdla_sdp_dp2wdma_pack

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 128: width of one datapath beat.
REQ-002 SHALL have parameter OUT_WIDTH, default 256: WDMA word width. RATIO = OUT_WIDTH/IN_WIDTH SHALL be 2, 4 or 8.
REQ-003 SHALL have port nvdla_core_clk, input, 1: clock.
REQ-004 SHALL have port nvdla_core_rstn, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port op_load, input, 1: single-cycle start-of-layer pulse.
REQ-006 SHALL have port dp_pvld, input, 1: datapath beat valid.
REQ-007 SHALL have port dp_prdy, output, 1: datapath beat ready.
REQ-008 SHALL have port dp_pd, input, IN_WIDTH: datapath beat payload.
REQ-009 SHALL have port dp_last, input, 1: beat closes a line; qualified by dp_pvld.
REQ-010 SHALL have port sdp_dp2wdma_valid, output, 1: packed word valid.
REQ-011 SHALL have port sdp_dp2wdma_ready, input, 1: WDMA ready.
REQ-012 SHALL have port sdp_dp2wdma_pd, output, OUT_WIDTH: packed word.
REQ-013 SHALL have port sdp_dp2wdma_mask, output, RATIO: per-slot data-present mask.
REQ-014 SHALL have port dp2reg_pack_stall, output, 32: output stall count (see Configuration).

Function
REQ-015 SHALL hold partial beats in an assembly register and a slot counter cnt of width log2(RATIO).
REQ-016 SHALL place accepted beat k of a word at bits [k*IN_WIDTH+IN_WIDTH-1 : k*IN_WIDTH].
REQ-017 SHALL treat a beat as completing when cnt==RATIO-1 or dp_last==1.
REQ-018 SHALL drive dp_prdy=1 for non-completing beats, and for completing beats only when (!sdp_dp2wdma_valid | sdp_dp2wdma_ready).
REQ-019 On an accepted non-completing beat, SHALL store the beat in slot cnt and increment cnt.
REQ-020 On an accepted completing beat, SHALL load the output register in the next cycle, with slots 0..cnt filled, higher slots zero, mask bits 0..cnt set and all other mask bits clear. SHALL also reset cnt to 0. Latency is 1 cycle.
REQ-021 SHALL hold sdp_dp2wdma_valid, pd and mask stable until sdp_dp2wdma_ready is sampled high.
REQ-022 SHALL support full throughput: a completing beat accepted in the same cycle the output drains gives back-to-back valid words with no bubble.
REQ-023 When op_load and an accepted beat occur in the same cycle, op_load SHALL win: cnt is cleared, the partial word is discarded, and the beat is dropped.
REQ-024 On op_load, SHALL clear cnt and the assembly register, and SHALL still deliver any word already in the output register.
REQ-025 With dp_last on slot 0, SHALL emit a word with mask=1 and the upper slots zero.

Reset
REQ-026 On nvdla_core_rstn low, SHALL asynchronously set cnt=0, assembly=0, sdp_dp2wdma_valid=0, sdp_dp2wdma_pd=0, sdp_dp2wdma_mask=0, dp2reg_pack_stall=0.
REQ-027 While in reset, dp_prdy SHALL be 1. Reset mid-word SHALL discard all partial and pending data.

Configuration
REQ-028 Macro NVDLA_SDP_PACK_PERF_EN controls the stall counter.
REQ-029 When NVDLA_SDP_PACK_PERF_EN is defined:
- dp2reg_pack_stall SHALL increment each cycle sdp_dp2wdma_valid & !sdp_dp2wdma_ready.
- It SHALL saturate at 0xFFFFFFFF.
- It SHALL clear to 0 on op_load; when op_load and a stall cycle coincide, the result is 0.
REQ-030 When NVDLA_SDP_PACK_PERF_EN is undefined, dp2reg_pack_stall SHALL be constant 0 and no counter flops SHALL exist.

Verification
REQ-031 RATIO=2, 4 beats A,B,C,D, ready=1 → words {B,A} then {D,C}, mask=2'b11, each valid 1 cycle after its completing beat.
REQ-032 RATIO=2, 3 beats with dp_last on beat 3 → {B,A} mask 11, then {0,C} mask 01.
REQ-033 Ready held 0 for 5 cycles while a word is pending → 1 further beat accepted, then dp_prdy=0 on the completing beat; pd unchanged; with PERF_EN, stall=5.
REQ-034 op_load after 1 beat of a RATIO=4 word → partial dropped; next 4 beats E,F,G,H → word {H,G,F,E} mask 1111.
REQ-035 Reset asserted with valid=1 pending → valid=0, cnt=0 immediately; after release, first beats pack from slot 0.
REQ-036 Stall counter preset near 0xFFFFFFFF (PERF_EN) → holds at 0xFFFFFFFF; op_load → 0.
